// File: rtl/exc_vector_seq_pkg.sv
// Shared constants for the exception entry/return sequencer: state codes,
// next-PC mux selects, vector addresses and cause codes.
package exc_vector_seq_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SAVE_EPC = 3'd1;
    localparam logic [2:0] ST_FETCH    = 3'd2;
    localparam logic [2:0] ST_LOAD_PC  = 3'd3;
    localparam logic [2:0] ST_RETURN   = 3'd4;

    localparam logic [1:0] PCS_SL  = 2'b00;
    localparam logic [1:0] PCS_EPC = 2'b01;
    localparam logic [1:0] PCS_ALU = 2'b10;
    localparam logic [1:0] PCS_VEC = 2'b11;

    localparam logic [31:0] VEC_ADDR_OPCODE   = 32'd253;
    localparam logic [31:0] VEC_ADDR_OVERFLOW = 32'd254;
    localparam logic [31:0] VEC_ADDR_DIV0     = 32'd255;

    localparam logic [1:0] CAUSE_OPCODE   = 2'd0;
    localparam logic [1:0] CAUSE_OVERFLOW = 2'd1;
    localparam logic [1:0] CAUSE_DIV0     = 2'd2;

    function automatic logic [31:0] vec_addr(input logic [1:0] code);
        case (code)
            CAUSE_OPCODE:   vec_addr = VEC_ADDR_OPCODE;
            CAUSE_OVERFLOW: vec_addr = VEC_ADDR_OVERFLOW;
            default:        vec_addr = VEC_ADDR_DIV0;
        endcase
    endfunction

endpackage

// File: rtl/exc_vector_seq_ack_wdt.sv
// Vector-fetch watchdog: loadable down-counter; expired_o rises once a
// started count has reached zero and stays up until cleared or restarted.
module ack_wdt #(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic start_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int unsigned CW = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (clear_i) begin
            cnt_d = '0;
            run_d = 1'b0;
        end else if (start_i) begin
            cnt_d = CW'(ACK_TIMEOUT);
            run_d = 1'b1;
        end else if (run_q && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign expired_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/exc_vector_seq.sv
// Exception entry/return sequencer driving the next-PC mux select.
// Optional cause register is built only when EXC_CAUSE_EN is defined.
module exc_vector_seq
    import exc_vector_seq_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 15,
    parameter logic [31:0] EPC_OFFSET  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_div0,
    input  logic        rte_req,
    input  logic [31:0] pc_in,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] epc_out,
    output logic        epc_we,
    output logic [7:0]  vec_byte,
    output logic [1:0]  pc_source,
    output logic        pc_we,
    output logic        busy,
    output logic        vec_timeout,
    output logic [31:0] cause
);

    logic [2:0]  state_q, state_d;
    logic [1:0]  code_q, code_d;
    logic [31:0] epc_q, epc_d;
    logic [7:0]  vec_q, vec_d;
    logic        wdt_start, wdt_clear, wdt_expired;
    logic        exc_any;

    assign exc_any = exc_opcode | exc_overflow | exc_div0;

    // Once the watchdog expires the fetch aborts even if an ack shows up in that same cycle.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        epc_d   = epc_q;
        vec_d   = vec_q;
        case (state_q)
            ST_IDLE: begin
                if (exc_any) begin
                    state_d = ST_SAVE_EPC;
                    epc_d   = pc_in - EPC_OFFSET;
                    if (exc_opcode)        code_d = CAUSE_OPCODE;
                    else if (exc_overflow) code_d = CAUSE_OVERFLOW;
                    else                   code_d = CAUSE_DIV0;
                end else if (rte_req) begin
                    state_d = ST_RETURN;
                end
            end
            ST_SAVE_EPC: state_d = ST_FETCH;
            ST_FETCH: begin
                if (wdt_expired) begin
                    vec_d   = 8'h00;
                    state_d = ST_LOAD_PC;
                end else if (mem_ack) begin
                    vec_d   = mem_rdata;
                    state_d = ST_LOAD_PC;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            code_q  <= CAUSE_OPCODE;
            epc_q   <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            epc_q   <= epc_d;
            vec_q   <= vec_d;
        end
    end

    assign wdt_start = (state_q == ST_SAVE_EPC);
    assign wdt_clear = (state_q == ST_LOAD_PC);

    ack_wdt #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_ack_wdt (
        .clk_i    (clk),
        .reset_i  (reset),
        .start_i  (wdt_start),
        .clear_i  (wdt_clear),
        .expired_o(wdt_expired)
    );

`ifdef EXC_CAUSE_EN
    logic [31:0] cause_q, cause_d;

    always_comb begin
        cause_d = cause_q;
        if (state_q == ST_SAVE_EPC) begin
            cause_d = {30'b0, code_q};
        end else if ((state_q == ST_FETCH) && wdt_expired) begin
            cause_d[31] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cause_q <= '0;
        else       cause_q <= cause_d;
    end

    assign cause = cause_q;
`else
    assign cause = 32'h0;
`endif

    assign busy        = (state_q != ST_IDLE);
    assign epc_we      = (state_q == ST_SAVE_EPC);
    assign epc_out     = epc_q;
    assign mem_req     = (state_q == ST_FETCH);
    assign mem_addr    = (state_q == ST_FETCH) ? vec_addr(code_q) : 32'h0;
    assign vec_byte    = vec_q;
    assign vec_timeout = (state_q == ST_FETCH) && wdt_expired;
    assign pc_we       = (state_q == ST_LOAD_PC) || (state_q == ST_RETURN);
    assign pc_source   = (state_q == ST_LOAD_PC) ? PCS_VEC :
                         (state_q == ST_RETURN)  ? PCS_EPC : PCS_SL;

endmodule

// File: tb/tb_exc_vector_seq.sv
// Bench for exc_vector_seq: transaction-level model checked every cycle plus
// directed scenarios with hand-computed values (EXC_CAUSE_EN optional).
module tb_exc_vector_seq;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        exc_opcode, exc_overflow, exc_div0, rte_req;
    logic [31:0] pc_in;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] epc_out;
    logic        epc_we;
    logic [7:0]  vec_byte;
    logic [1:0]  pc_source;
    logic        pc_we;
    logic        busy;
    logic        vec_timeout;
    logic [31:0] cause;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exc_vector_seq #(
        .ACK_TIMEOUT(TO),
        .EPC_OFFSET (32'd4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .exc_opcode  (exc_opcode),
        .exc_overflow(exc_overflow),
        .exc_div0    (exc_div0),
        .rte_req     (rte_req),
        .pc_in       (pc_in),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .epc_out     (epc_out),
        .epc_we      (epc_we),
        .vec_byte    (vec_byte),
        .pc_source   (pc_source),
        .pc_we       (pc_we),
        .busy        (busy),
        .vec_timeout (vec_timeout),
        .cause       (cause)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Transaction model: mN counts cycles since the request was accepted,
    // mFetchEnd is the cycle in which the vector fetch finished (0 = still fetching).
    bit          mActive = 1'b0;
    bit          mIsRte = 1'b0;
    int          mN = 0;
    int          mFetchEnd = 0;
    logic [1:0]  mCode = 2'd0;
    logic [31:0] mEpc = 32'h0;
    logic [7:0]  mVec = 8'h0;
    logic [31:0] mCause = 32'h0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mActive   <= 1'b0;
            mIsRte    <= 1'b0;
            mN        <= 0;
            mFetchEnd <= 0;
            mCode     <= 2'd0;
            mEpc      <= 32'h0;
            mVec      <= 8'h0;
            mCause    <= 32'h0;
        end else if (!mActive) begin
            if (exc_opcode || exc_overflow || exc_div0) begin
                mActive   <= 1'b1;
                mIsRte    <= 1'b0;
                mN        <= 1;
                mFetchEnd <= 0;
                mEpc      <= pc_in - 32'd4;
                mCode     <= exc_opcode ? 2'd0 : (exc_overflow ? 2'd1 : 2'd2);
            end else if (rte_req) begin
                mActive <= 1'b1;
                mIsRte  <= 1'b1;
                mN      <= 1;
            end
        end else if (mIsRte || (mFetchEnd != 0)) begin
            mActive <= 1'b0;
        end else begin
            if (mN == 1) begin
`ifdef EXC_CAUSE_EN
                mCause <= {30'b0, mCode};
`endif
            end else if (mN - 1 == TO + 1) begin
                mVec      <= 8'h00;
                mFetchEnd <= mN;
`ifdef EXC_CAUSE_EN
                mCause[31] <= 1'b1;
`endif
            end else if (mem_ack) begin
                mVec      <= mem_rdata;
                mFetchEnd <= mN;
            end
            mN <= mN + 1;
        end
    end

    always @(negedge clk) begin
        bit eFetch, eLoad, eRet, eSave;
        eSave  = mActive && !mIsRte && (mN == 1);
        eFetch = mActive && !mIsRte && (mN >= 2) && (mFetchEnd == 0);
        eLoad  = mActive && !mIsRte && (mFetchEnd != 0);
        eRet   = mActive && mIsRte;
        checkOutput("busy", {31'b0, busy}, {31'b0, mActive});
        checkOutput("epc_we", {31'b0, epc_we}, {31'b0, eSave});
        checkOutput("epc_out", epc_out, mEpc);
        checkOutput("mem_req", {31'b0, mem_req}, {31'b0, eFetch});
        checkOutput("mem_addr", mem_addr, eFetch ? 32'(253 + int'(mCode)) : 32'h0);
        checkOutput("vec_timeout", {31'b0, vec_timeout}, {31'b0, eFetch && (mN == TO + 2)});
        checkOutput("vec_byte", {24'b0, vec_byte}, {24'b0, mVec});
        checkOutput("pc_we", {31'b0, pc_we}, {31'b0, eLoad || eRet});
        checkOutput("pc_source", {30'b0, pc_source}, eLoad ? 32'd3 : (eRet ? 32'd1 : 32'd0));
        checkOutput("cause", cause, mCause);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic sampleNeg();
        @(negedge clk);
        #1;
    endtask

    // Presents a one-cycle request; returns just after the accepting edge (cycle 1).
    task automatic applyStimulus(input logic opc, input logic ovf, input logic dz,
                                 input logic rte, input logic [31:0] pc);
        exc_opcode   = opc;
        exc_overflow = ovf;
        exc_div0     = dz;
        rte_req      = rte;
        pc_in        = pc;
        tick();
        exc_opcode   = 1'b0;
        exc_overflow = 1'b0;
        exc_div0     = 1'b0;
        rte_req      = 1'b0;
    endtask

    initial begin
        int seenAt;
        reset = 1'b1;
        exc_opcode = 1'b0; exc_overflow = 1'b0; exc_div0 = 1'b0; rte_req = 1'b0;
        pc_in = 32'h0; mem_ack = 1'b0; mem_rdata = 8'h0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        sampleNeg();
        checkOutput("reset busy", {31'b0, busy}, 32'd0);
        checkOutput("reset pc_source", {30'b0, pc_source}, 32'd0);

        // Overflow, ack in first fetch cycle
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0040);
        sampleNeg();
        checkOutput("t1 epc_we", {31'b0, epc_we}, 32'd1);
        checkOutput("t1 epc_out", epc_out, 32'h0000_003C);
        tick(); mem_ack = 1'b1; mem_rdata = 8'h7F;
        sampleNeg();
        checkOutput("t1 mem_req", {31'b0, mem_req}, 32'd1);
        checkOutput("t1 mem_addr", mem_addr, 32'd254);
        tick(); mem_ack = 1'b0; mem_rdata = 8'h00;
        sampleNeg();
        checkOutput("t1 pc_we", {31'b0, pc_we}, 32'd1);
        checkOutput("t1 pc_source", {30'b0, pc_source}, 32'd3);
        checkOutput("t1 vec_byte", {24'b0, vec_byte}, 32'h7F);
        tick();
        sampleNeg();
        checkOutput("t1 idle", {31'b0, busy}, 32'd0);

        // Opcode + div0 together; overflow pulse while busy is ignored
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0100);
        tick(); exc_overflow = 1'b1;
        sampleNeg();
        checkOutput("t2 mem_addr", mem_addr, 32'd253);
        tick(); exc_overflow = 1'b0;
`ifdef EXC_CAUSE_EN
        sampleNeg();
        checkOutput("t2 cause", cause, 32'h0);
`endif
        tick(); mem_ack = 1'b1; mem_rdata = 8'h80;
        tick(); mem_ack = 1'b0;
        sampleNeg();
        checkOutput("t2 vec_byte", {24'b0, vec_byte}, 32'h80);
        checkOutput("t2 pc_source", {30'b0, pc_source}, 32'd3);
        tick();
        sampleNeg();
        checkOutput("t2 idle", {31'b0, busy}, 32'd0);

        // RTE alone
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0500);
        sampleNeg();
        checkOutput("t3 pc_we", {31'b0, pc_we}, 32'd1);
        checkOutput("t3 pc_source", {30'b0, pc_source}, 32'd1);
        tick();
        sampleNeg();
        checkOutput("t3 busy after", {31'b0, busy}, 32'd0);
        checkOutput("t3 pc_we after", {31'b0, pc_we}, 32'd0);

        // RTE with div0: exception wins
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0200);
        sampleNeg();
        checkOutput("t3b epc_we", {31'b0, epc_we}, 32'd1);
        checkOutput("t3b pc_source", {30'b0, pc_source}, 32'd0);
        tick(); mem_ack = 1'b1; mem_rdata = 8'h01;
        sampleNeg();
        checkOutput("t3b mem_addr", mem_addr, 32'd255);
        tick(); mem_ack = 1'b0;
        sampleNeg();
        checkOutput("t3b vec_byte", {24'b0, vec_byte}, 32'h01);
        tick();
        sampleNeg();
        checkOutput("t3b no return", {31'b0, busy}, 32'd0);

        // No ack: watchdog abort
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0300);
        seenAt = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            sampleNeg();
            if (vec_timeout) begin
                seenAt = cyc;
                break;
            end
            tick();
        end
        checkOutput("t4 timeout cycle", seenAt, 32'd17);
        tick();
        sampleNeg();
        checkOutput("t4 pc_source", {30'b0, pc_source}, 32'd3);
        checkOutput("t4 vec_byte", {24'b0, vec_byte}, 32'h00);
        checkOutput("t4 vec_timeout gone", {31'b0, vec_timeout}, 32'd0);
`ifdef EXC_CAUSE_EN
        checkOutput("t4 cause", cause, 32'h8000_0002);
`endif
        tick();

        // Reset in the middle of a fetch
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0400);
        tick();
        tick();
        sampleNeg();
        checkOutput("t5 mem_req before", {31'b0, mem_req}, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("t5 mem_req", {31'b0, mem_req}, 32'd0);
        checkOutput("t5 busy", {31'b0, busy}, 32'd0);
        checkOutput("t5 epc_out", epc_out, 32'h0);
        checkOutput("t5 mem_addr", mem_addr, 32'h0);
        checkOutput("t5 cause", cause, 32'h0);
        @(posedge clk);
        #3 reset = 1'b0;
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0002);
        sampleNeg();
        checkOutput("t6 epc_we", {31'b0, epc_we}, 32'd1);
        checkOutput("t6 epc_out wrap", epc_out, 32'hFFFF_FFFE);
        tick(); mem_ack = 1'b1; mem_rdata = 8'h55;
        tick(); mem_ack = 1'b0;
        sampleNeg();
        checkOutput("t6 vec_byte", {24'b0, vec_byte}, 32'h55);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exc_vector_seq.md
# exc_vector_seq

Exception entry/return sequencer that drives the PCSource selection feeding the 4:1 next-PC multiplexer (00 jump target, 01 EPC, 10 ALUOut, 11 sign-extended vector byte). On an exception it:
- captures EPC;
- fetches the 8-bit handler vector from the fixed vector address;
- loads PC through select 11.

On RTE it loads PC from EPC through select 01. It sits beside the main control FSM, which stalls while `busy` is high.

## Interface
Parameters:
- ACK_TIMEOUT, 15: maximum cycles FETCH waits for `mem_ack` before aborting.
- EPC_OFFSET, 4: value subtracted from the captured PC to form EPC.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- exc_opcode  in  1  invalid-opcode exception request (level, sampled in IDLE)
- exc_overflow  in  1  arithmetic overflow request
- exc_div0  in  1  divide-by-zero request
- rte_req  in  1  return-from-exception request
- pc_in  in  32  current (already incremented) PC
- mem_ack  in  1  memory read complete; `mem_rdata` valid this cycle
- mem_rdata  in  8  vector byte from memory
- mem_req  out  1  vector read request
- mem_addr  out  32  vector address
- epc_out  out  32  EPC value to write
- epc_we  out  1  EPC write strobe
- vec_byte  out  8  latched vector byte, routed to the 8→32 sign-extender
- pc_source  out  2  next-PC mux select
- pc_we  out  1  PC write strobe
- busy  out  1  high in every state except IDLE
- vec_timeout  out  1  one-cycle pulse on FETCH abort
- cause  out  32  cause register (see Configuration)

## Operation
- States: IDLE, SAVE_EPC, FETCH, LOAD_PC, RETURN.
- **IDLE**
  - Any exception input high: latch `pc_in` and the winning cause, then go to SAVE_EPC.
  - Else if `rte_req`: go to RETURN.
  - Priority: exc_opcode > exc_overflow > exc_div0 > rte_req.
  - Exception and rte_req in the same cycle: the exception wins and the RTE is dropped.
- **SAVE_EPC**
  - `epc_we`=1, `epc_out` = latched PC − EPC_OFFSET, modulo 2^32 (0x00000002 wraps to 0xFFFFFFFE).
  - Next state: FETCH.
- **FETCH**
  - `mem_req`=1, `mem_addr` = 253 (opcode), 254 (overflow) or 255 (div0).
  - Held stable until `mem_ack` is sampled high. On that cycle `vec_byte` ← `mem_rdata`; next state: LOAD_PC.
  - Watchdog (ack_wdt): if ACK_TIMEOUT cycles elapse without ack, `vec_byte` ← 0x00, `vec_timeout` pulses, next state: LOAD_PC.
- **LOAD_PC**
  - `pc_source`=11, `pc_we`=1 for exactly one cycle; then IDLE.
  - `vec_byte` holds its value until the next FETCH completes.
- **RETURN**
  - `pc_source`=01, `pc_we`=1 for one cycle; then IDLE.
- Exception inputs asserted while `busy` are ignored, with no queueing. They are re-sampled once the block is back in IDLE.
- Outside LOAD_PC/RETURN: `pc_source`=00 and `pc_we`=0.
- Reset (any state, including mid-FETCH):
  - state → IDLE; `mem_req` drops asynchronously.
  - all outputs 0: epc_out, vec_byte, cause, strobes and `pc_source`=00.
  - watchdog counter cleared.

## Timing
- Exception sampled at edge 0:
  - `epc_we` high in cycle 1.
  - `mem_req` from cycle 2.
  - With ack in cycle 2, `pc_we`/`pc_source`=11 in cycle 3, IDLE in cycle 4. Minimum latency 3 cycles to PC write.
- RTE sampled at edge 0: `pc_we` with `pc_source`=01 in cycle 1. Latency 1.
- All outputs are registered or decoded from state only. No combinational path from inputs to outputs.
- Watchdog abort: LOAD_PC occurs ACK_TIMEOUT+1 cycles after FETCH entry.

## Configuration
- EXC_CAUSE_EN defined:
  - `cause` is written in SAVE_EPC with code 0x0 (opcode), 0x1 (overflow) or 0x2 (div0) in bits [1:0].
  - Bit 31 is set if the vector fetch timed out.
  - The register holds its value until the next exception or reset.
- Undefined: `cause` is tied to 32'h0 and no cause storage is synthesized.

## Structure
- Shared package holds:
  - state enum;
  - PCSource encodings (PCS_SL=00, PCS_EPC=01, PCS_ALU=10, PCS_VEC=11);
  - vector addresses (253/254/255);
  - cause codes.
- Sub-module `ack_wdt`: loadable down-counter with `start`, `clear` and `expired`, parameterized by ACK_TIMEOUT.

## Test plan
- exc_overflow pulse, pc_in=0x00000040, ack next cycle with 0x7F → epc_out=0x0000003C with epc_we in cycle 1, mem_addr=254, vec_byte=0x7F, pc_source=11 with pc_we in cycle 3.
- exc_opcode and exc_div0 together → mem_addr=253; with EXC_CAUSE_EN, cause=0x0.
- rte_req alone → pc_source=01, pc_we=1 for one cycle in cycle 1, busy low afterwards; rte_req together with exc_div0 → mem_addr=255, no RETURN.
- mem_ack never asserted → vec_timeout pulse after 15 FETCH cycles, vec_byte=0x00, pc_source=11; with EXC_CAUSE_EN, cause[31]=1.
- Reset asserted mid-FETCH → mem_req low immediately, all outputs 0, busy=0; a new exception after release restarts from SAVE_EPC.
- pc_in=0x00000002 → epc_out=0xFFFFFFFE.
